// File: rtl/prod_sched_pkg.sv
// Shared types, widths and helpers for the product-block scheduler.
package prod_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int PB_OPND_W = 4;
    localparam int PB_PROD_W = 8;
    localparam logic [PB_PROD_W-1:0] PB_PROD_MAX = 8'd255;

    // Exact reference product of two 4-bit operands (max 225, fits in 8 bits).
    function automatic logic [PB_PROD_W-1:0] exact_prod(
        input logic [PB_OPND_W-1:0] w,
        input logic [PB_OPND_W-1:0] x
    );
        return {4'b0000, w} * {4'b0000, x};
    endfunction

    // Pulse counter step that sticks at the maximum value.
    function automatic logic [PB_PROD_W-1:0] sat_inc(
        input logic [PB_PROD_W-1:0] cnt,
        input logic                 pulse
    );
        if (pulse && (cnt != PB_PROD_MAX)) begin
            return cnt + 8'd1;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/prod_block_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    int              cand_s;
    logic [ID_W-1:0] cand_idx_s;

    // Walk the requesters in priority order starting just after last_grant.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = 0;
        cand_idx_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = int'(last_grant) + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = ID_W'(cand_s);
            if (en && !grant_valid && req[cand_idx_s]) begin
                grant[cand_idx_s] = 1'b1;
                grant_idx         = cand_idx_s;
                grant_valid       = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/prod_block_sched.sv
// Scheduler for one shared product block: arbitrates operand pairs, starts the
// block, counts its unary output pulses over a fixed window and reports the
// product together with a mismatch flag against the exact w*x.
module prod_block_sched
    import prod_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WINDOW  = 256
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][PB_OPND_W-1:0] req_w,
    input  logic [NUM_REQ-1:0][PB_OPND_W-1:0] req_x,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            pb_in_rdy,
    output logic [PB_OPND_W-1:0]            pb_w,
    output logic [PB_OPND_W-1:0]            pb_x,
    input  logic                            pb_out,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [PB_PROD_W-1:0]            rsp_prod,
    output logic                            rsp_mismatch
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    sched_state_t           state_r;
    logic [ID_W-1:0]        last_grant_r;
    logic [ID_W-1:0]        g_r;
    logic [PB_OPND_W-1:0]   w_r;
    logic [PB_OPND_W-1:0]   x_r;
    logic [PB_PROD_W-1:0]   pulse_cnt_r;
    logic [WIN_W-1:0]       win_cnt_r;
    logic                   pb_in_rdy_r;
    logic                   rsp_valid_r;
    logic [ID_W-1:0]        rsp_id_r;
    logic [PB_PROD_W-1:0]   rsp_prod_r;
    logic                   rsp_mismatch_r;

    logic [NUM_REQ-1:0]     grant_s;
    logic [ID_W-1:0]        grant_idx_s;
    logic                   grant_valid_s;
    logic                   arb_en_s;
    logic [PB_PROD_W-1:0]   cnt_next_s;

    assign arb_en_s   = (state_r == IDLE);
    assign cnt_next_s = sat_inc(pulse_cnt_r, pb_out);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req_valid),
        .last_grant  (last_grant_r),
        .en          (arb_en_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Grant is only offered while idle, so it is the accept strobe itself.
    assign req_ready    = grant_s;
    assign pb_in_rdy    = pb_in_rdy_r;
    assign pb_w         = w_r;
    assign pb_x         = x_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = rsp_id_r;
    assign rsp_prod     = rsp_prod_r;
    assign rsp_mismatch = rsp_mismatch_r;

    // Operation sequencer: accept, start pulse, count window, hold response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            last_grant_r   <= ID_W'(NUM_REQ - 1);
            g_r            <= '0;
            w_r            <= '0;
            x_r            <= '0;
            pulse_cnt_r    <= '0;
            win_cnt_r      <= '0;
            pb_in_rdy_r    <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_id_r       <= '0;
            rsp_prod_r     <= '0;
            rsp_mismatch_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        g_r         <= grant_idx_s;
                        w_r         <= req_w[grant_idx_s];
                        x_r         <= req_x[grant_idx_s];
                        pb_in_rdy_r <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    pb_in_rdy_r <= 1'b0;
                    pulse_cnt_r <= '0;
                    win_cnt_r   <= '0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    pulse_cnt_r <= cnt_next_s;
                    if (win_cnt_r == WIN_LAST) begin
                        // The final window cycle's pulse is folded in here.
                        rsp_prod_r     <= cnt_next_s;
                        rsp_mismatch_r <= (cnt_next_s != exact_prod(w_r, x_r));
                        rsp_id_r       <= g_r;
                        rsp_valid_r    <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        win_cnt_r <= win_cnt_r + WIN_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r  <= 1'b0;
                        last_grant_r <= g_r;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    pb_in_rdy_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
